// File: rtl/dc_bu_pkg.sv
`default_nettype none
// ============================================================================
// dc_bu_pkg : ring helpers shared across the buffering-unit blocks
// Rev 1.0
// ============================================================================
package dc_bu_pkg;

    // Width of an index into a ring of n entries (never zero).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

    function automatic int unsigned wrap_add(input int unsigned v, input int unsigned k,
                                             input int unsigned n);
        return (v + k) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dc_bu_line_ring_if.sv
`default_nettype none
// ============================================================================
// dc_bu_line_ring_if : pixel write / window read bundle of the line ring
// Rev 1.0
// ============================================================================
interface dc_bu_line_ring_if #(
    parameter int BUFFER_NUM      = 5,
    parameter int BITS_PER_PIXEL  = 24,
    parameter int BUFF_ADDR_WIDTH = 11,
    parameter int WINDOW          = 4
);
    localparam int CNT_W = $clog2(BUFFER_NUM + 1);

    logic                               en;
    logic                               flush;
    logic [BUFF_ADDR_WIDTH-1:0]         line_len;
    logic                               wr_valid;
    logic [BITS_PER_PIXEL-1:0]          wr_data;
    logic                               wr_ready;
    logic                               rd_req;
    logic [BUFF_ADDR_WIDTH-1:0]         rd_addr;
    logic                               rd_ready;
    logic                               rd_release;
    logic [WINDOW*BITS_PER_PIXEL-1:0]   rdata;
    logic                               rdata_valid;
    logic [CNT_W-1:0]                   lines_avail;
    logic                               ovf;

    modport master (
        output en, flush, line_len, wr_valid, wr_data, rd_req, rd_addr, rd_release,
        input  wr_ready, rd_ready, rdata, rdata_valid, lines_avail, ovf
    );

    modport slave (
        input  en, flush, line_len, wr_valid, wr_data, rd_req, rd_addr, rd_release,
        output wr_ready, rd_ready, rdata, rdata_valid, lines_avail, ovf
    );
endinterface
`default_nettype wire

// File: rtl/dc_bu_memory.sv
`default_nettype none
// ============================================================================
// dc_bu_memory : single line memory, one write port, registered read port
// Rev 1.0
// ============================================================================
module dc_bu_memory #(
    parameter int DEPTH = 1920,
    parameter int WIDTH = 24,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset: the array maps onto block RAM and its output latch.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/dc_bu_line_ring.sv
`default_nettype none
// ============================================================================
// dc_bu_line_ring : circular line store returning an oldest-first window of lines
// Rev 1.0
// ============================================================================
module dc_bu_line_ring
    import dc_bu_pkg::*;
#(
    parameter int BUFFER_NUM      = 5,
    parameter int BUFFER_SIZE     = 1920,
    parameter int BITS_PER_PIXEL  = 24,
    parameter int BUFF_ADDR_WIDTH = 11,
    parameter int WINDOW          = 4,
    parameter int RD_LAT          = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    dc_bu_line_ring_if.slave      bus_if
);
    localparam int PTR_W = ptr_width(BUFFER_NUM);
    localparam int CNT_W = $clog2(BUFFER_NUM + 1);
    localparam int BPP   = BITS_PER_PIXEL;
    localparam int WBITS = WINDOW * BPP;
    localparam int AW    = BUFF_ADDR_WIDTH;

    logic [PTR_W-1:0] wr_line_q, rd_base_q, base0_q;
    logic [AW-1:0]    wr_col_q;
    logic [CNT_W-1:0] full_q, full_d;
    logic             ovf_q, v0_q;

    logic go, wr_ready, rd_ready, wr_acc, line_done, rel_acc, rd_acc;

    // flush wins over every other accept in its cycle
    assign go        = bus_if.en & ~bus_if.flush;
    assign wr_ready  = full_q < CNT_W'(BUFFER_NUM);
    assign rd_ready  = full_q >= CNT_W'(WINDOW);
    assign wr_acc    = go & bus_if.wr_valid & wr_ready;
    assign line_done = wr_acc & (wr_col_q == (bus_if.line_len - AW'(1)));
    assign rel_acc   = go & bus_if.rd_release & (full_q != '0);
    assign rd_acc    = go & bus_if.rd_req & rd_ready;

    always_comb begin
        full_d = full_q;
        case ({line_done, rel_acc})
            2'b10:   full_d = full_q + CNT_W'(1);
            2'b01:   full_d = full_q - CNT_W'(1);
            default: full_d = full_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_line_q <= '0;
            rd_base_q <= '0;
            wr_col_q  <= '0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
            v0_q      <= 1'b0;
            base0_q   <= '0;
        end else if (bus_if.en) begin
            if (bus_if.flush) begin
                wr_line_q <= '0;
                rd_base_q <= '0;
                wr_col_q  <= '0;
                full_q    <= '0;
                ovf_q     <= 1'b0;
            end else begin
                if (wr_acc)
                    wr_col_q <= line_done ? '0 : wr_col_q + AW'(1);
                if (line_done)
                    wr_line_q <= PTR_W'(wrap_inc(32'(wr_line_q), BUFFER_NUM));
                if (rel_acc)
                    rd_base_q <= PTR_W'(wrap_inc(32'(rd_base_q), BUFFER_NUM));
                if (bus_if.wr_valid & ~wr_ready)
                    ovf_q <= 1'b1;
                full_q <= full_d;
            end
            // The window base rides along with the read so a same-cycle release cannot skew it.
            v0_q <= rd_acc;
            if (rd_acc) base0_q <= rd_base_q;
        end
    end

    logic [BPP-1:0] mem_rd [BUFFER_NUM];

    for (genvar i = 0; i < BUFFER_NUM; i++) begin : g_mem
        dc_bu_memory #(
            .DEPTH (BUFFER_SIZE),
            .WIDTH (BPP),
            .AW    (AW)
        ) u_mem (
            .clk     (clk),
            .we_i    (wr_acc & (wr_line_q == PTR_W'(i))),
            .waddr_i (wr_col_q),
            .wdata_i (bus_if.wr_data),
            .re_i    (rd_acc),
            .raddr_i (bus_if.rd_addr),
            .rdata_o (mem_rd[i])
        );
    end

    logic [WBITS-1:0] win;

    always_comb begin
        win = '0;
        for (int k = 0; k < WINDOW; k++)
            win[k*BPP +: BPP] = mem_rd[PTR_W'(wrap_add(32'(base0_q), k, BUFFER_NUM))];
    end

    if (RD_LAT == 0) begin : g_lat0
        assign bus_if.rdata       = win;
        assign bus_if.rdata_valid = v0_q;
    end else begin : g_latn
        logic [WBITS-1:0]  d_q [RD_LAT];
        logic [RD_LAT-1:0] v_q;

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                for (int i = 0; i < RD_LAT; i++) d_q[i] <= '0;
                v_q <= '0;
            end else if (bus_if.en) begin
                v_q[0] <= v0_q & ~bus_if.flush;
                if (v0_q) d_q[0] <= win;
                for (int i = 1; i < RD_LAT; i++) begin
                    v_q[i] <= v_q[i-1] & ~bus_if.flush;
                    if (v_q[i-1]) d_q[i] <= d_q[i-1];
                end
            end
        end

        assign bus_if.rdata       = d_q[RD_LAT-1];
        assign bus_if.rdata_valid = v_q[RD_LAT-1];
    end

    assign bus_if.wr_ready    = wr_ready;
    assign bus_if.rd_ready    = rd_ready;
    assign bus_if.lines_avail = full_q;
    assign bus_if.ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dc_bu_line_ring.sv
`default_nettype none
// ============================================================================
// tb_dc_bu_line_ring : randomized + directed bench against a line-level model
// Rev 1.0
// ============================================================================
module tb_dc_bu_line_ring;
    localparam int N    = 5;
    localparam int SIZE = 1920;
    localparam int BPP  = 24;
    localparam int AW   = 11;
    localparam int W    = 4;
    localparam int LAT  = 1;
    localparam int WB   = W * BPP;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    dc_bu_line_ring_if #(.BUFFER_NUM(N), .BITS_PER_PIXEL(BPP),
                         .BUFF_ADDR_WIDTH(AW), .WINDOW(W)) bus ();

    dc_bu_line_ring #(
        .BUFFER_NUM(N), .BUFFER_SIZE(SIZE), .BITS_PER_PIXEL(BPP),
        .BUFF_ADDR_WIDTH(AW), .WINDOW(W), .RD_LAT(LAT)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .bus_if (bus)
    );

    typedef struct {
        int            due;
        logic [WB-1:0] data;
    } exp_t;

    // Model: lines are numbered forever; line L lives in slot L % N.
    logic [BPP-1:0] m_mem [N][SIZE];
    int   n_done, n_rel, m_col, m_len, ecyc;
    bit   m_ovf;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        n_done = 0; n_rel = 0; m_col = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic step(input bit e, input bit wv, input logic [BPP-1:0] wd, input bit rq,
                        input logic [AW-1:0] ra, input bit rel, input bit fl);
        int   held;
        bit   wacc, racc, lacc, exp_v;
        exp_t x;
        @(negedge clk);
        bus.en = e; bus.wr_valid = wv; bus.wr_data = wd; bus.rd_req = rq;
        bus.rd_addr = ra; bus.rd_release = rel; bus.flush = fl;
        bus.line_len = AW'(m_len);
        #1;
        held = n_done - n_rel;
        check_val("wr_ready", 128'(bus.wr_ready), 128'(held < N));
        check_val("rd_ready", 128'(bus.rd_ready), 128'(held >= W));
        check_val("lines_avail", 128'(bus.lines_avail), 128'(held));
        check_val("ovf", 128'(bus.ovf), 128'(m_ovf));
        if (e) begin
            if (fl) begin
                model_clear();
            end else begin
                wacc = wv && (held < N);
                racc = rq && (held >= W);
                lacc = rel && (held > 0);
                if (wv && !wacc) m_ovf = 1;
                if (racc) begin
                    x.due = ecyc + 1 + LAT;
                    for (int k = 0; k < W; k++)
                        x.data[k*BPP +: BPP] = m_mem[(n_rel + k) % N][ra];
                    q.push_back(x);
                end
                if (wacc) begin
                    m_mem[n_done % N][m_col] = wd;
                    if (m_col == m_len - 1) begin
                        m_col = 0;
                        n_done++;
                    end else begin
                        m_col++;
                    end
                end
                if (lacc) n_rel++;
            end
            ecyc++;
        end
        @(posedge clk);
        #1;
        while (q.size() > 0 && q[0].due < ecyc) void'(q.pop_front());
        exp_v = (q.size() > 0) && (q[0].due == ecyc);
        check_val("rdata_valid", 128'(bus.rdata_valid), 128'(exp_v));
        if (exp_v) check_val("rdata", 128'(bus.rdata), 128'(q[0].data));
    endtask

    task automatic idle();
        step(1, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic wr_line(input int l);
        for (int c = 0; c < m_len; c++) step(1, 1, BPP'(l * 16 + c), 0, '0, 0, 0);
    endtask

    initial begin
        bus.en = 1; bus.flush = 0; bus.line_len = 8; bus.wr_valid = 0; bus.wr_data = '0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.rd_release = 0;
        m_len = 8; ecyc = 0;
        model_clear();
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Fill four lines and read one column of the window.
        idle();
        for (int l = 0; l < 4; l++) wr_line(l);
        check_val("tp1_rd_ready", 128'(bus.rd_ready), 128'(1));
        step(1, 0, '0, 1, AW'(3), 0, 0);
        idle();
        check_val("tp1_window", 128'(bus.rdata), 128'({24'h33, 24'h23, 24'h13, 24'h03}));

        // Fill the ring, then overrun it.
        wr_line(4);
        check_val("tp2_lines5", 128'(bus.lines_avail), 128'(5));
        check_val("tp2_wr_ready", 128'(bus.wr_ready), 128'(0));
        step(1, 1, BPP'(24'hAA), 0, '0, 0, 0);
        check_val("tp2_ovf", 128'(bus.ovf), 128'(1));
        step(1, 0, '0, 1, AW'(0), 0, 0);
        idle();
        check_val("tp2_mem_kept", 128'(bus.rdata), 128'({24'h30, 24'h20, 24'h10, 24'h00}));

        // Release three, write two more: window wraps across the ring.
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0, 1, 0);
        wr_line(5);
        wr_line(6);
        step(1, 0, '0, 1, AW'(0), 0, 0);
        idle();
        check_val("tp3_wrap", 128'(bus.rdata), 128'({24'h60, 24'h50, 24'h40, 24'h30}));

        // Completion and release in one cycle, then read and release in one cycle.
        for (int c = 0; c < 7; c++) step(1, 1, BPP'(8'h70 + c), 0, '0, 0, 0);
        step(1, 1, BPP'(8'h77), 0, '0, 1, 0);
        check_val("tp4_same_cycle", 128'(bus.lines_avail), 128'(4));
        step(1, 0, '0, 1, AW'(2), 1, 0);
        idle();
        check_val("tp4_pre_release", 128'(bus.rdata), 128'({24'h72, 24'h62, 24'h52, 24'h42}));

        // Back-to-back reads with a three-cycle enable gap.
        wr_line(8);
        for (int c = 0; c < 3; c++) step(1, 0, '0, 1, AW'(c), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, BPP'(24'h55), 1, AW'(7), 1, 0);
        for (int c = 3; c < 6; c++) step(1, 0, '0, 1, AW'(c), 0, 0);
        idle();
        idle();

        // Flush with a read in flight and three lines held.
        step(1, 0, '0, 1, AW'(1), 1, 0);
        check_val("tp6_held3", 128'(bus.lines_avail), 128'(3));
        step(1, 0, '0, 0, '0, 0, 1);
        check_val("tp6_flush_avail", 128'(bus.lines_avail), 128'(0));
        check_val("tp6_flush_valid", 128'(bus.rdata_valid), 128'(0));
        check_val("tp6_flush_ovf", 128'(bus.ovf), 128'(0));
        check_val("tp6_flush_wr_ready", 128'(bus.wr_ready), 128'(1));

        // Asynchronous reset mid-line with a read in flight.
        for (int l = 0; l < 4; l++) wr_line(l);
        for (int c = 0; c < 3; c++) step(1, 1, BPP'(8'h40 + c), 0, '0, 0, 0);
        step(1, 0, '0, 1, AW'(5), 0, 0);
        @(negedge clk);
        bus.rd_req = 0; bus.wr_valid = 0; bus.rd_release = 0;
        #2 nrst = 1'b0;
        #1;
        check_val("rst_avail", 128'(bus.lines_avail), 128'(0));
        check_val("rst_valid", 128'(bus.rdata_valid), 128'(0));
        check_val("rst_rdata", 128'(bus.rdata), 128'(0));
        check_val("rst_wr_ready", 128'(bus.wr_ready), 128'(1));
        check_val("rst_ovf", 128'(bus.ovf), 128'(0));
        model_clear();
        @(negedge clk);
        nrst = 1'b1;

        // Randomized traffic with occasional flush / line length change.
        for (int i = 0; i < 4000; i++) begin
            bit e, wv, rq, rel, fl;
            e   = ($urandom_range(0, 9) != 0);
            wv  = ($urandom_range(0, 9) < 7);
            rq  = ($urandom_range(0, 1) == 1);
            rel = ($urandom_range(0, 9) < 2);
            fl  = ($urandom_range(0, 199) == 0);
            if (fl) begin
                e = 1;
                m_len = int'($urandom_range(1, 12));
            end
            step(e, wv, BPP'($urandom), rq, AW'($urandom_range(0, m_len - 1)), rel, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dc_bu_line_ring.md
# dc_bu_line_ring

Parametrised line-ring buffer for the buffering unit of the HDMI scaler. It stores incoming pixel lines into a circular set of BUFFER_NUM line memories and tracks which lines are complete. It exposes a vertical window of WINDOW consecutive lines, read at one column per request and re-ordered oldest-to-newest, to the downstream vertical interpolator. It adds ring rotation, fill/space flow control, a configurable output pipeline and overrun detection on top of the fixed five-buffer cluster.

## Interface
- BUFFER_NUM, 5, number of line memories in the ring (≥ 2)
- BUFFER_SIZE, 1920, pixels per line memory
- BITS_PER_PIXEL, 24, pixel word width
- BUFF_ADDR_WIDTH, 11, column address width (≥ $clog2(BUFFER_SIZE))
- WINDOW, 4, lines returned per read (1 ≤ WINDOW ≤ BUFFER_NUM-1)
- RD_LAT, 1, extra output register stages after memory read (0..2)
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- en  in  1  global clock enable; when low all state, including the pipeline, holds
- flush  in  1  synchronous clear of pointers, counts, pipeline valids and ovf
- line_len  in  BUFF_ADDR_WIDTH  active pixels per line, 1..BUFFER_SIZE; stable except in the flush cycle
- wr_valid  in  1  pixel present on wr_data
- wr_data  in  BITS_PER_PIXEL  pixel
- wr_ready  out  1  free line slot exists
- rd_req  in  1  window read request
- rd_addr  in  BUFF_ADDR_WIDTH  column to read
- rd_ready  out  1  at least WINDOW complete lines held
- rd_release  in  1  retire oldest complete line
- rdata  out  WINDOW*BITS_PER_PIXEL  slot k at bits [k*BPP +: BPP]; slot 0 is the oldest line
- rdata_valid  out  1  rdata holds the result of an accepted request
- lines_avail  out  $clog2(BUFFER_NUM+1)  complete, unreleased lines
- ovf  out  1  sticky: write attempted while wr_ready low

## Operation
- State: wr_line and rd_base (ring indices, mod BUFFER_NUM), wr_col (column), full_lines (count).
- wr_ready = full_lines < BUFFER_NUM. rd_ready = full_lines ≥ WINDOW. lines_avail = full_lines.
- Write accept (en & wr_valid & wr_ready): mem[wr_line][wr_col] ← wr_data. If wr_col == line_len-1: wr_col ← 0, wr_line ← wr_line+1 with wrap, line completes. Otherwise wr_col++.
- en & wr_valid & !wr_ready: data dropped, ovf ← 1.
- Read accept (en & rd_req & rd_ready): all WINDOW memories at lines rd_base+k (mod BUFFER_NUM) are read at rd_addr. The captured rd_base travels with the request to drive the reorder mux.
- Release accept (en & rd_release & full_lines > 0): rd_base++ with wrap. Released while full_lines == 0: ignored.
- full_lines: +1 on line completion, -1 on accepted release, unchanged when both occur in the same cycle.
- A read and a release in the same cycle: the read returns the pre-release window.
- rd_addr ≥ line_len: rdata undefined, rdata_valid still asserted.
- flush (with en): wr_line, rd_base, wr_col, full_lines, ovf and pipeline valids ← 0. Memory contents are untouched. flush overrides all simultaneous accepts.
- Reset values: wr_ready 1, rd_ready 0, rdata_valid 0, rdata 0 (RD_LAT ≥ 1; don't-care while rdata_valid is 0 when RD_LAT = 0), lines_avail 0, ovf 0.

## Timing
- Write to readable: a line becomes visible to rd_ready in the cycle after its last pixel is accepted.
- Read latency: rdata_valid is high exactly 1+RD_LAT enabled cycles after the accept. Back-to-back requests are accepted every cycle.
- en low freezes the pipeline in place. No bubbles are inserted and no data is lost.
- Asynchronous reset mid-operation: all state clears immediately and in-flight reads are discarded.

## Structure
- Package dc_bu_pkg holds the ring pointer width function and a wrap-increment function shared with other buffering-unit blocks.
- Sub-module: the existing dc_bu_memory (registered read, one cycle), instantiated BUFFER_NUM times in a generate loop. The reorder mux and RD_LAT stages are local.

## Test plan
- BUFFER_NUM=5, WINDOW=4, line_len=8: write 4 lines with pixel = line*16+col -> rd_ready rises after pixel 31. Read col 3 -> rdata slots {0x03,0x13,0x23,0x33} 2 cycles later (RD_LAT=1).
- Write 5 lines with no release -> wr_ready low and lines_avail=5. A 6th wr_valid sets ovf, and memory is unchanged.
- Steady state, 7 lines written, 3 releases -> read col 0 returns lines 3..6 in slot order, checking wrap across the ring.
- Same-cycle line completion and rd_release -> lines_avail unchanged. Same-cycle read and release -> pre-release window returned.
- en low for 3 cycles during back-to-back reads -> rdata_valid and rdata hold, and the sequence resumes unchanged.
- flush with 3 lines held and a read in flight -> lines_avail=0, rdata_valid=0, ovf=0, wr_ready=1 next cycle. nrst asserted mid-line gives the same result.
